// File: rtl/keypad_scanner.sv
`default_nettype none
// ===== keypad_scanner : NROWS x NCOLS matrix keypad scanner with debounced press/release events =====
// ===== Revision 1.0 =================================================================================
module keypad_scanner #(
  parameter int NROWS           = 4,
  parameter int NCOLS           = 4,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic [NROWS-1:0]               rows,
  output logic [NCOLS-1:0]               cols,
  output logic [$clog2(NROWS*NCOLS)-1:0] key_code,
  output logic                           key_valid,
  output logic                           key_held,
  output logic                           key_released,
  output logic                           multi_key
);

  localparam int KW     = $clog2(NROWS*NCOLS);
  localparam int c_CLW  = $clog2(NCOLS);
  localparam int c_MAXC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int c_CW   = $clog2(c_MAXC + 1);

  localparam logic [c_CW-1:0]  c_SETTLE_LAST = c_CW'(SETTLE_CYCLES - 1);
  localparam logic [c_CW-1:0]  c_DEB_LAST    = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CW-1:0]  c_CNT_ONE     = c_CW'(1);
  localparam logic [c_CLW-1:0] c_COL_LAST    = c_CLW'(NCOLS - 1);
  localparam logic [c_CLW-1:0] c_COL_ONE     = c_CLW'(1);
  localparam logic [NCOLS-1:0] c_COL_BIT0    = NCOLS'(1);

  typedef enum logic [1:0] {SCAN, DEB_P, HELD, DEB_R} state_t;

  state_t           state_q;
  logic [NROWS-1:0] rs_meta_q, rs_q, pat_q;
  logic [c_CW-1:0]  cnt_q;
  logic [c_CLW-1:0] col_q;
  logic [NCOLS-1:0] cols_q;
  logic [KW-1:0]    code_q;
  logic             valid_q, held_q, released_q, multi_q;

  logic             rs_idle, rs_single, accept, release_done;
  logic [c_CLW-1:0] col_nxt;
  logic [KW-1:0]    rs_code;
  int               row_sel;

  assign rs_idle   = &rs_q;
  assign rs_single = ($countones(~rs_q) == 1);
  assign col_nxt   = (col_q == c_COL_LAST) ? '0 : col_q + c_COL_ONE;

  always_comb begin
    row_sel = 0;
    for (int r = 0; r < NROWS; r++) begin
      if (!rs_q[r]) row_sel = r;
    end
  end

  assign rs_code = KW'(row_sel * NCOLS + int'(col_q));

  // A single-sample debounce accepts straight from the scan sample / first idle sample.
  assign accept = (DEBOUNCE_CYCLES == 1)
      ? (state_q == SCAN  && cnt_q == c_SETTLE_LAST && !rs_idle)
      : (state_q == DEB_P && rs_q == pat_q && cnt_q == c_DEB_LAST);

  assign release_done = (DEBOUNCE_CYCLES == 1)
      ? (state_q == HELD  && rs_idle)
      : (state_q == DEB_R && rs_idle && cnt_q == c_DEB_LAST);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= SCAN;
      rs_meta_q  <= '1;
      rs_q       <= '1;
      pat_q      <= '1;
      cnt_q      <= '0;
      col_q      <= '0;
      cols_q     <= ~c_COL_BIT0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      released_q <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      rs_meta_q  <= rows;
      rs_q       <= rs_meta_q;
      valid_q    <= 1'b0;
      released_q <= 1'b0;
      if (accept) begin
        state_q <= HELD;
        if (rs_single) begin
          code_q  <= rs_code;
          valid_q <= 1'b1;
          held_q  <= 1'b1;
        end else begin
          multi_q <= 1'b1;
        end
      end else if (release_done) begin
        state_q    <= SCAN;
        cnt_q      <= '0;
        col_q      <= col_nxt;
        cols_q     <= ~(c_COL_BIT0 << col_nxt);
        released_q <= ~multi_q;
        held_q     <= 1'b0;
        multi_q    <= 1'b0;
      end else begin
        case (state_q)
          SCAN: begin
            if (cnt_q != c_SETTLE_LAST) begin
              cnt_q <= cnt_q + c_CNT_ONE;
            end else if (rs_idle) begin
              cnt_q  <= '0;
              col_q  <= col_nxt;
              cols_q <= ~(c_COL_BIT0 << col_nxt);
            end else begin
              pat_q   <= rs_q;
              cnt_q   <= c_CNT_ONE;
              state_q <= DEB_P;
            end
          end
          DEB_P: begin
            if (rs_q != pat_q) begin
              state_q <= SCAN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + c_CNT_ONE;
            end
          end
          HELD: begin
            if (rs_idle) begin
              state_q <= DEB_R;
              cnt_q   <= c_CNT_ONE;
            end
          end
          DEB_R: begin
            if (!rs_idle) state_q <= HELD;
            else          cnt_q   <= cnt_q + c_CNT_ONE;
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign cols         = cols_q;
  assign key_code     = code_q;
  assign key_valid    = valid_q;
  assign key_held     = held_q;
  assign key_released = released_q;
  assign multi_key    = multi_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ===== tb_keypad_scanner : keypad-matrix emulation plus scan-timeline arithmetic =====
// ===== Revision 1.0 ==================================================================
module tb_keypad_scanner;
  localparam int NROWS  = 4;
  localparam int NCOLS  = 4;
  localparam int SETTLE = 4;
  localparam int DEB    = 8;
  localparam int KW     = $clog2(NROWS*NCOLS);

  logic             clk = 1'b0;
  logic             nreset;
  logic [NROWS-1:0] rows;
  logic [NCOLS-1:0] cols;
  logic [KW-1:0]    key_code;
  logic             key_valid, key_held, key_released, multi_key;

  logic [NCOLS-1:0] pk [NROWS];
  int cyc = 0;
  int nvalid = 0, nrel = 0, nboth = 0, valid_cyc = -1, rel_cyc = -1;
  int errors = 0, checks = 0;
  int base_cyc = 0, base_col = 0;

  keypad_scanner #(
    .NROWS(NROWS), .NCOLS(NCOLS), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .nreset(nreset), .rows(rows), .cols(cols), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .key_released(key_released),
    .multi_key(multi_key)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin nvalid <= nvalid + 1; valid_cyc <= cyc; end
    if (key_released === 1'b1) begin nrel <= nrel + 1; rel_cyc <= cyc; end
    if (key_valid === 1'b1 && key_released === 1'b1) nboth <= nboth + 1;
  end

  // A pressed key pulls its row low whenever its column is driven low.
  always_comb begin
    rows = '1;
    for (int r = 0; r < NROWS; r++)
      for (int c = 0; c < NCOLS; c++)
        if (pk[r][c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [NCOLS-1:0] colmask(input int c);
    logic [NCOLS-1:0] m;
    m = '1;
    m[c] = 1'b0;
    return m;
  endfunction

  // Idle scan: column (base_col + k) is driven during cycles base_cyc+SETTLE*k .. +SETTLE-1,
  // sampled in the last of those; the synchroniser shows rows from two cycles earlier.
  function automatic int first_sample(input int c, input int p);
    int t;
    t = base_cyc + SETTLE - 1 + SETTLE * (((c - base_col) % NCOLS + NCOLS) % NCOLS);
    while (t - 2 < p) t += SETTLE * NCOLS;
    return t;
  endfunction

  task automatic press_key(input int r, input int c);
    int p, t, nv0, k;
    p = cyc;
    nv0 = nvalid;
    pk[r][c] = 1'b1;
    t = first_sample(c, p);
    k = 0;
    while (nvalid == nv0 && k < 300) begin tick(1); k++; end
    chk("press_count", 32'(nvalid - nv0), 32'(1));
    chk("press_latency", 32'(valid_cyc), 32'(t + DEB));
    chk("press_code", 32'(key_code), 32'(r * NCOLS + c));
    chk("press_held", 32'(key_held), 32'(1));
    chk("press_multi", 32'(multi_key), 32'(0));
  endtask

  task automatic release_key(input int r, input int c);
    int q, nr0, nv0, k;
    chk("hold_cols", 32'(cols), 32'(colmask(c)));
    chk("hold_held", 32'(key_held), 32'(1));
    q = cyc;
    nr0 = nrel;
    nv0 = nvalid;
    pk[r][c] = 1'b0;
    k = 0;
    while (nrel == nr0 && k < 300) begin tick(1); k++; end
    chk("release_count", 32'(nrel - nr0), 32'(1));
    chk("release_latency", 32'(rel_cyc), 32'(q + 2 + DEB));
    chk("release_held", 32'(key_held), 32'(0));
    chk("release_code", 32'(key_code), 32'(r * NCOLS + c));
    chk("release_no_valid", 32'(nvalid - nv0), 32'(0));
    chk("release_next_col", 32'(cols), 32'(colmask((c + 1) % NCOLS)));
    base_cyc = rel_cyc;
    base_col = (c + 1) % NCOLS;
  endtask

  initial begin
    int nv0, nr0, s, k, p, t, q, code0, rr, cc, d, h;
    nreset = 1'b0;
    for (int r = 0; r < NROWS; r++) pk[r] = '0;
    tick(3);
    chk("rst_cols", 32'(cols), 32'(colmask(0)));
    chk("rst_code", 32'(key_code), 32'(0));
    chk("rst_valid", 32'(key_valid), 32'(0));
    chk("rst_held", 32'(key_held), 32'(0));
    chk("rst_released", 32'(key_released), 32'(0));
    chk("rst_multi", 32'(multi_key), 32'(0));
    nreset = 1'b1;
    base_cyc = cyc;
    base_col = 0;

    repeat (64) begin
      chk("idle_cols", 32'(cols), 32'(colmask((base_col + (cyc - base_cyc) / SETTLE) % NCOLS)));
      tick(1);
    end
    chk("idle_no_valid", 32'(nvalid), 32'(0));

    tick(5);
    press_key(1, 2);
    tick(12);
    release_key(1, 2);

    nv0 = nvalid;
    for (int i = 0; i < 10; i++) begin
      pk[0][0] = ~pk[0][0];
      tick(3);
    end
    chk("bounce_quiet", 32'(nvalid - nv0), 32'(0));
    s = cyc;
    pk[0][0] = 1'b1;
    k = 0;
    while (nvalid == nv0 && k < 300) begin tick(1); k++; end
    chk("bounce_count", 32'(nvalid - nv0), 32'(1));
    chk("bounce_after_stable", 32'(valid_cyc >= s + 2 + DEB), 32'(1));
    chk("bounce_code", 32'(key_code), 32'(0));
    tick(20);
    release_key(0, 0);

    for (int i = 0; i < 6; i++) begin
      rr = int'($urandom_range(0, NROWS - 1));
      cc = int'($urandom_range(0, NCOLS - 1));
      d  = int'($urandom_range(1, 20));
      h  = int'($urandom_range(1, 30));
      tick(d);
      press_key(rr, cc);
      tick(h);
      release_key(rr, cc);
    end

    tick(3);
    code0 = int'(key_code);
    p = cyc;
    nv0 = nvalid;
    nr0 = nrel;
    pk[0][3] = 1'b1;
    pk[1][3] = 1'b1;
    t = first_sample(3, p);
    k = 0;
    while (multi_key !== 1'b1 && k < 300) begin tick(1); k++; end
    chk("chord_latency", 32'(cyc), 32'(t + DEB));
    chk("chord_no_valid", 32'(nvalid - nv0), 32'(0));
    chk("chord_held", 32'(key_held), 32'(0));
    chk("chord_code", 32'(key_code), 32'(code0));
    chk("chord_cols", 32'(cols), 32'(colmask(3)));
    tick(10);
    chk("chord_still", 32'(multi_key), 32'(1));
    q = cyc;
    pk[0][3] = 1'b0;
    pk[1][3] = 1'b0;
    k = 0;
    while (multi_key !== 1'b0 && k < 300) begin tick(1); k++; end
    chk("chord_release_latency", 32'(cyc), 32'(q + 2 + DEB));
    base_cyc = cyc;
    base_col = 0;
    tick(1);
    chk("chord_no_release", 32'(nrel - nr0), 32'(0));
    chk("chord_code_kept", 32'(key_code), 32'(code0));

    tick(2);
    p = cyc;
    pk[2][1] = 1'b1;
    t = first_sample(1, p);
    tick(t + 3 - cyc);
    nreset = 1'b0;
    tick(1);
    chk("mid_rst_cols", 32'(cols), 32'(colmask(0)));
    chk("mid_rst_code", 32'(key_code), 32'(0));
    chk("mid_rst_valid", 32'(key_valid), 32'(0));
    chk("mid_rst_held", 32'(key_held), 32'(0));
    chk("mid_rst_released", 32'(key_released), 32'(0));
    chk("mid_rst_multi", 32'(multi_key), 32'(0));
    nreset = 1'b1;
    base_cyc = cyc;
    base_col = 0;
    press_key(2, 1);
    tick(5);
    release_key(2, 1);

    tick(2);
    chk("never_both", 32'(nboth), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
